uart_rx_sampler: RTL and testbench
==================================

UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10416, clk cycles per bit period; legal range 8..65535.
REQ-002 SHALL have port clk input 1: the single clock; all state updates on posedge.
REQ-003 SHALL have port rst input 1: synchronous, active-high reset.
REQ-004 SHALL have port rx input 1: asynchronous serial line; idles high.
REQ-005 SHALL have port rx_data output 8: received byte, LSB first on the line.
REQ-006 SHALL have port rx_valid output 1: one-cycle pulse, rx_data valid; drives the RX FIFO write enable with no backpressure.
REQ-007 SHALL have port frame_err output 1: one-cycle pulse when the stop bit samples low.
REQ-008 SHALL have port busy output 1: high in every state except IDLE.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer (reset value 1); all logic below uses the synchronized value rxs.
REQ-010 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE -> START on rxs == 0; bit counter cleared to 0.
REQ-011 SHALL use a 16-bit cycle counter that restarts at 0 on each state entry and on each bit boundary.
REQ-012 SHALL take each bit value as the 2-of-3 majority of rxs sampled at counter values M-1, M, M+1, where M = CLKS_PER_BIT/2 (START) or CLKS_PER_BIT-1 (DATA, STOP).
REQ-013 SHALL, in START, return to IDLE with no output if the majority value is 1 (glitch reject); otherwise enter DATA.
REQ-014 SHALL, in DATA, shift each majority bit in at the MSB ({bit, shift[7:1]}), then enter STOP after the 8th bit.
REQ-015 SHALL, in STOP, on majority 1: load rx_data, pulse rx_valid for one cycle beginning the cycle after the M+1 sample, and return to IDLE.
REQ-016 SHALL, in STOP, on majority 0: pulse frame_err with the same timing, leave rx_data unchanged, assert no rx_valid, and enter WAIT_HIGH.
REQ-017 SHALL leave WAIT_HIGH for IDLE only after rxs is 1 for one full cycle (break condition: no further events).
REQ-018 SHALL hold rx_data stable between rx_valid pulses.
REQ-019 SHALL never assert rx_valid and frame_err in the same cycle.
REQ-020 SHALL allow back-to-back frames: a start edge in the cycle after the STOP-to-IDLE transition is accepted.

Reset
REQ-021 SHALL on rst: state=IDLE, counters=0, shift=0, rx_data=0, rx_valid=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-022 SHALL abort any in-progress frame on rst with no pulse; a frame already in flight when rst deasserts is received only from its next start edge.

Configuration
REQ-023 SHALL, with macro UART_RX_PARITY_EN defined, add state PARITY between DATA and STOP, sampling an even-parity bit the same way, plus output parity_err (1 bit, one-cycle pulse with REQ-015 timing, asserted instead of rx_valid on mismatch; reset 0).
REQ-024 SHALL, without UART_RX_PARITY_EN, have no PARITY state and no parity_err port; frame = 1 start + 8 data + 1 stop.

Structure
REQ-025 SHALL place the FSM state enum and the default bit-period localparam in shared package uart_pkg, reused by the TX side.
REQ-026 SHALL implement the 2-flop synchronizer as sub-module uart_sync (parameter RESET_VAL); all other logic stays in this module.

Verification (CLKS_PER_BIT=16)
REQ-027 SHALL cover: byte 0xA5, 8N1, ideal timing -> one rx_valid pulse, rx_data=0xA5, frame_err never asserted.
REQ-028 SHALL cover: rx low for 4 cycles then high -> FSM returns to IDLE, no rx_valid, no frame_err.
REQ-029 SHALL cover: byte 0x3C with stop bit held low for 40 cycles -> frame_err pulses once, rx_data unchanged, busy until rx high, then IDLE.
REQ-030 SHALL cover: bytes 0x00, 0xFF, 0x55 back-to-back with zero idle gap -> three rx_valid pulses in order with matching data.
REQ-031 SHALL cover: a 1-cycle inverted glitch at the center of each data bit of 0x96 -> still received as 0x96 (majority vote).
REQ-032 SHALL cover: rst asserted mid-DATA of 0x81, then a clean 0x42 -> no event for 0x81, rx_valid with 0x42; with UART_RX_PARITY_EN defined, a wrong parity bit on 0x42 -> parity_err pulse, no rx_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, default bit period and vote helper
// Optional PARITY state is present only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 10416;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } uart_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchronizer for an asynchronous single-bit input
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - UART receiver with 3-sample majority vote per bit
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam logic [15:0] ST_S0  = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] ST_S1  = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] ST_S2  = 16'(CLKS_PER_BIT / 2 + 1);
    localparam logic [15:0] BIT_S0 = 16'(CLKS_PER_BIT - 2);
    localparam logic [15:0] BIT_S1 = 16'(CLKS_PER_BIT - 1);

    logic        rxs;
    uart_state_t state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  shift, shift_n;
    logic [7:0]  data_n;
    logic        s0, s0_n, s1, s1_n;
    logic        pend, pend_n;
    logic        valid_n, ferr_n;
    logic        vote;
`ifdef UART_RX_PARITY_EN
    logic        par_bad, par_bad_n;
    logic        perr_n;
`endif

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            s0        <= 1'b1;
            s1        <= 1'b1;
            pend      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            s0        <= s0_n;
            s1        <= s1_n;
            pend      <= pend_n;
            rx_data   <= data_n;
            rx_valid  <= valid_n;
            frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par_bad    <= par_bad_n;
            parity_err <= perr_n;
`endif
        end
    end

    // Bit periods are exactly CLKS_PER_BIT long: the counter wraps after the
    // M sample and the third (M+1) sample is voted in the first cycle of the
    // following period, flagged by pend.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 16'd1;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        s0_n      = s0;
        s1_n      = s1;
        pend_n    = 1'b0;
        data_n    = rx_data;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad;
        perr_n    = 1'b0;
`endif
        vote      = maj3(s0, s1, rxs);

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxs) begin
                    state_n   = START;
                    bit_cnt_n = '0;
                end
            end
            START: begin
                if (cnt == ST_S0) s0_n = rxs;
                if (cnt == ST_S1) s1_n = rxs;
                if (cnt == ST_S2) begin
                    cnt_n   = '0;
                    state_n = vote ? IDLE : DATA;
                end
            end
            WAIT_HIGH: begin
                cnt_n = '0;
                if (rxs) state_n = IDLE;
            end
            default: begin
                if (cnt == BIT_S0) s0_n = rxs;
                if (cnt == BIT_S1) begin
                    s1_n   = rxs;
                    cnt_n  = '0;
                    pend_n = 1'b1;
                end
                if (pend) begin
                    case (state)
                        DATA: begin
                            shift_n   = {vote, shift[7:1]};
                            bit_cnt_n = bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                cnt_n = '0;
`ifdef UART_RX_PARITY_EN
                                state_n = PARITY;
`else
                                state_n = STOP;
`endif
                            end
                        end
`ifdef UART_RX_PARITY_EN
                        PARITY: begin
                            par_bad_n = (^shift) ^ vote;
                            cnt_n     = '0;
                            state_n   = STOP;
                        end
`endif
                        STOP: begin
                            cnt_n = '0;
                            if (vote) begin
                                state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                                if (par_bad) begin
                                    perr_n = 1'b1;
                                end else begin
                                    valid_n = 1'b1;
                                    data_n  = shift;
                                end
`else
                                valid_n = 1'b1;
                                data_n  = shift;
`endif
                            end else begin
                                ferr_n  = 1'b1;
                                state_n = WAIT_HIGH;
                            end
                        end
                        default: state_n = IDLE;
                    endcase
                end
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb/tb_uart_rx_sampler.sv - directed self-checking bench for uart_rx_sampler
// Define UART_RX_PARITY_EN to exercise the parity variant.
module tb_uart_rx_sampler;

    localparam int BIT = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       par_flip;
    int         n_perr;
`endif

    int         n_cmp;
    int         n_bad;
    int         n_ferr;
    int         n_both;
    logic [7:0] got_data[$];

    uart_rx_sampler #(.CLKS_PER_BIT(BIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) got_data.push_back(rx_data);
        if (frame_err === 1'b1) n_ferr++;
        if (rx_valid === 1'b1 && frame_err === 1'b1) n_both++;
`ifdef UART_RX_PARITY_EN
        if (parity_err === 1'b1) n_perr++;
        if (parity_err === 1'b1 && (rx_valid === 1'b1 || frame_err === 1'b1)) n_both++;
`endif
    end

    task automatic clear_logs();
        got_data.delete();
        n_ferr = 0;
`ifdef UART_RX_PARITY_EN
        n_perr = 0;
`endif
    endtask

    task automatic drive(input logic v, input int cycles);
        rx = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_len);
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(b[i], BIT);
`ifdef UART_RX_PARITY_EN
        drive((^b) ^ par_flip, BIT);
`endif
        drive(stop_val, stop_len);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp += 4;
        if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        rst = 1'b0;
        drive(1'b1, 5);
    endtask

    task automatic test_ideal();
        clear_logs();
        send_frame(8'hA5, 1'b1, BIT);
        drive(1'b1, 8);
        n_cmp += 4;
        if (got_data.size() !== 1) begin n_bad++; $display("FAIL ideal_count got=%0d exp=1", got_data.size()); end
        else if (got_data[0] !== 8'hA5) begin n_bad++; $display("FAIL ideal_data got=%h exp=a5", got_data[0]); end
        if (n_ferr !== 0) begin n_bad++; $display("FAIL ideal_ferr got=%0d exp=0", n_ferr); end
        if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL ideal_hold got=%h exp=a5", rx_data); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL ideal_idle busy=%b exp=0", busy); end
    endtask

    task automatic test_start_glitch();
        clear_logs();
        drive(1'b0, 4);
        n_cmp += 5;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy got=%b exp=1", busy); end
        drive(1'b1, 30);
        if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_idle busy=%b exp=0", busy); end
        if (got_data.size() !== 0) begin n_bad++; $display("FAIL glitch_valid got=%0d exp=0", got_data.size()); end
        if (n_ferr !== 0) begin n_bad++; $display("FAIL glitch_ferr got=%0d exp=0", n_ferr); end
        if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL glitch_hold got=%h exp=a5", rx_data); end
    endtask

    task automatic test_frame_err();
        clear_logs();
        send_frame(8'h3C, 1'b0, 40);
        n_cmp += 5;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL ferr_busy got=%b exp=1", busy); end
        drive(1'b1, 5);
        if (busy !== 1'b0) begin n_bad++; $display("FAIL ferr_idle busy=%b exp=0", busy); end
        drive(1'b1, 20);
        if (n_ferr !== 1) begin n_bad++; $display("FAIL ferr_count got=%0d exp=1", n_ferr); end
        if (got_data.size() !== 0) begin n_bad++; $display("FAIL ferr_valid got=%0d exp=0", got_data.size()); end
        if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL ferr_hold got=%h exp=a5", rx_data); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[3];
        exp_q = '{8'h00, 8'hFF, 8'h55};
        clear_logs();
        for (int i = 0; i < 3; i++) send_frame(exp_q[i], 1'b1, BIT);
        drive(1'b1, 10);
        n_cmp += 1;
        if (got_data.size() !== 3) begin
            n_bad++;
            $display("FAIL b2b_count got=%0d exp=3", got_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (got_data[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL b2b_data[%0d] got=%h exp=%h", i, got_data[i], exp_q[i]);
                end
            end
        end
        n_cmp++;
        if (n_ferr !== 0) begin n_bad++; $display("FAIL b2b_ferr got=%0d exp=0", n_ferr); end
    endtask

    task automatic test_majority();
        logic [7:0] b;
        b = 8'h96;
        clear_logs();
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) begin
            drive(b[i], 10);
            drive(~b[i], 1);
            drive(b[i], 5);
        end
`ifdef UART_RX_PARITY_EN
        drive((^b) ^ par_flip, BIT);
`endif
        drive(1'b1, BIT);
        drive(1'b1, 8);
        n_cmp += 2;
        if (got_data.size() !== 1) begin n_bad++; $display("FAIL maj_count got=%0d exp=1", got_data.size()); end
        else if (got_data[0] !== 8'h96) begin n_bad++; $display("FAIL maj_data got=%h exp=96", got_data[0]); end
        if (n_ferr !== 0) begin n_bad++; $display("FAIL maj_ferr got=%0d exp=0", n_ferr); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] b;
        b = 8'h81;
        clear_logs();
        drive(1'b0, BIT);
        for (int i = 0; i < 3; i++) drive(b[i], BIT);
        rst = 1'b1;
        for (int i = 3; i < 8; i++) drive(b[i], BIT);
        n_cmp += 3;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        rst = 1'b0;
        drive(1'b1, BIT + 20);
        if (got_data.size() !== 0 || n_ferr !== 0) begin
            n_bad++;
            $display("FAIL abort_event valid=%0d ferr=%0d exp=0/0", got_data.size(), n_ferr);
        end
        if (rx_data !== 8'h00) begin n_bad++; $display("FAIL abort_rx_data got=%h exp=00", rx_data); end
        send_frame(8'h42, 1'b1, BIT);
        drive(1'b1, 8);
        n_cmp += 2;
        if (got_data.size() !== 1) begin n_bad++; $display("FAIL abort_next_count got=%0d exp=1", got_data.size()); end
        else if (got_data[0] !== 8'h42) begin n_bad++; $display("FAIL abort_next_data got=%h exp=42", got_data[0]); end
        if (n_ferr !== 0) begin n_bad++; $display("FAIL abort_next_ferr got=%0d exp=0", n_ferr); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_logs();
        par_flip = 1'b1;
        send_frame(8'h42, 1'b1, BIT);
        drive(1'b1, 8);
        par_flip = 1'b0;
        n_cmp += 3;
        if (n_perr !== 1) begin n_bad++; $display("FAIL parity_err_count got=%0d exp=1", n_perr); end
        if (got_data.size() !== 0) begin n_bad++; $display("FAIL parity_valid got=%0d exp=0", got_data.size()); end
        if (rx_data !== 8'h42) begin n_bad++; $display("FAIL parity_hold got=%h exp=42", rx_data); end
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        n_ferr = 0;
        n_both = 0;
`ifdef UART_RX_PARITY_EN
        par_flip = 1'b0;
        n_perr   = 0;
`endif
        rst = 1'b1;
        rx  = 1'b1;
        test_reset();
        test_ideal();
        test_start_glitch();
        test_frame_err();
        test_back_to_back();
        test_majority();
        test_reset_abort();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        n_cmp++;
        if (n_both !== 0) begin n_bad++; $display("FAIL pulse_overlap got=%0d exp=0", n_both); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
